// File: rtl/pipeline_pkg.sv
// Shared definitions for the MEM/WB pipeline stage: write-back control bit
// positions, stage state encoding and the default-width MEM/WB bundle.
package pipeline_pkg;

  // Positions inside the 2-bit write-back control field.
  localparam int WB_REG_WRITE_BIT  = 1;
  localparam int WB_MEM_TO_REG_BIT = 0;
  localparam int WB_WIDTH          = 2;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_REG_ADDR_WIDTH = 5;

  // State bits double as the valid bits: bit0 = main valid, bit1 = skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } stageState_t;

  // MEM/WB bundle at the default widths.
  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0]     memWord;
    logic [DEFAULT_DATA_WIDTH-1:0]     aluResult;
    logic [DEFAULT_REG_ADDR_WIDTH-1:0] rd;
    logic [WB_WIDTH-1:0]               wb;
  } memWbBundle_t;

endpackage

// File: rtl/mem_wb_slot.sv
// One enable-loaded bundle register with asynchronous active-low reset.
module mem_wb_slot #(
  parameter int unsigned WIDTH = 71
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Payload register: loads on enable, cleared by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// in_ready depends only on registered state, so downstream back-pressure never
// reaches the upstream stage combinationally.
module mem_wb_skid_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
  parameter bit          ZERO_REG_GUARD = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_mem_word,
  input  logic [DATA_WIDTH-1:0]     in_alu_result,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic [1:0]                in_wb,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_mem_word,
  output logic [DATA_WIDTH-1:0]     out_alu_result,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      out_reg_write,
  output logic                      out_mem_to_reg,
  output logic [DATA_WIDTH-1:0]     out_wb_data
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     memWord;
    logic [DATA_WIDTH-1:0]     aluResult;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [WB_WIDTH-1:0]       wb;
  } bundle_t;

  localparam int unsigned BundleWidth = $bits(bundle_t);

  stageState_t stateQ, stateD;
  bundle_t     inBundle, mainD, mainQ, skidQ;
  logic        mainLoad, skidLoad;
  logic        mainValid, accept, retire;

  assign inBundle = '{memWord: in_mem_word, aluResult: in_alu_result, rd: in_rd, wb: in_wb};

  assign mainValid = (stateQ != EMPTY);
  assign in_ready  = (stateQ != TWO);
  assign accept    = in_valid & in_ready;
  assign retire    = mainValid & out_ready;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stateQ <= EMPTY;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next state and slot load enables; flush wins and leaves payloads stale.
  always_comb begin
    stateD   = stateQ;
    mainLoad = 1'b0;
    skidLoad = 1'b0;
    mainD    = inBundle;
    if (flush) begin
      stateD = EMPTY;
    end else begin
      unique case (stateQ)
        EMPTY: begin
          if (accept) begin
            stateD   = ONE;
            mainLoad = 1'b1;
          end
        end
        ONE: begin
          if (accept && retire) begin
            mainLoad = 1'b1;
          end else if (accept) begin
            stateD   = TWO;
            skidLoad = 1'b1;
          end else if (retire) begin
            stateD = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only the skid entry can move up.
          if (retire) begin
            stateD   = ONE;
            mainLoad = 1'b1;
            mainD    = skidQ;
          end
        end
        default: stateD = EMPTY;
      endcase
    end
  end

  mem_wb_slot #(
    .WIDTH (BundleWidth)
  ) mainSlot (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (mainLoad),
    .d       (mainD),
    .q       (mainQ)
  );

  mem_wb_slot #(
    .WIDTH (BundleWidth)
  ) skidSlot (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (skidLoad),
    .d       (inBundle),
    .q       (skidQ)
  );

  // Head-of-queue outputs, qualified by main valid where they cause side effects.
  always_comb begin
    out_valid      = mainValid;
    out_mem_word   = mainQ.memWord;
    out_alu_result = mainQ.aluResult;
    out_rd         = mainQ.rd;
    out_mem_to_reg = mainValid & mainQ.wb[WB_MEM_TO_REG_BIT];
    out_reg_write  = mainValid & mainQ.wb[WB_REG_WRITE_BIT]
                   & ((ZERO_REG_GUARD == 1'b0) | (mainQ.rd != '0));
    out_wb_data    = mainQ.wb[WB_MEM_TO_REG_BIT] ? mainQ.memWord : mainQ.aluResult;
  end

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Self-checking bench for mem_wb_skid_stage: a 2-deep queue model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_mem_wb_skid_stage;

  typedef struct packed {
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [1:0]  wb;
  } bund_t;

  logic        clock = 1'b0;
  logic        reset_n, flush, inValid, outReady;
  logic [31:0] inMem, inAlu;
  logic [4:0]  inRd;
  logic [1:0]  inWb;

  logic        inReady, outValid, outRegWrite, outMemToReg;
  logic [31:0] outMem, outAlu, outWbData;
  logic [4:0]  outRd;

  logic        ngInReady, ngOutValid, ngOutRegWrite, ngOutMemToReg;
  logic [31:0] ngOutMem, ngOutAlu, ngOutWbData;
  logic [4:0]  ngOutRd;

  int    total = 0;
  int    bad = 0;
  bund_t model[$];

  always #5 clock = ~clock;

  mem_wb_skid_stage #(
    .DATA_WIDTH     (32),
    .REG_ADDR_WIDTH (5),
    .ZERO_REG_GUARD (1'b1)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .flush          (flush),
    .in_valid       (inValid),
    .in_ready       (inReady),
    .in_mem_word    (inMem),
    .in_alu_result  (inAlu),
    .in_rd          (inRd),
    .in_wb          (inWb),
    .out_valid      (outValid),
    .out_ready      (outReady),
    .out_mem_word   (outMem),
    .out_alu_result (outAlu),
    .out_rd         (outRd),
    .out_reg_write  (outRegWrite),
    .out_mem_to_reg (outMemToReg),
    .out_wb_data    (outWbData)
  );

  mem_wb_skid_stage #(
    .DATA_WIDTH     (32),
    .REG_ADDR_WIDTH (5),
    .ZERO_REG_GUARD (1'b0)
  ) dutNg (
    .clock          (clock),
    .reset_n        (reset_n),
    .flush          (flush),
    .in_valid       (inValid),
    .in_ready       (ngInReady),
    .in_mem_word    (inMem),
    .in_alu_result  (inAlu),
    .in_rd          (inRd),
    .in_wb          (inWb),
    .out_valid      (ngOutValid),
    .out_ready      (outReady),
    .out_mem_word   (ngOutMem),
    .out_alu_result (ngOutAlu),
    .out_rd         (ngOutRd),
    .out_reg_write  (ngOutRegWrite),
    .out_mem_to_reg (ngOutMemToReg),
    .out_wb_data    (ngOutWbData)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [1:0] wb);
    inValid = v;
    inRd    = rd;
    inMem   = mem;
    inAlu   = alu;
    inWb    = wb;
  endtask

  // Outputs must match the head of the model queue.
  task automatic checkModel();
    bund_t h;
    chk("in_ready", 64'(inReady), 64'(model.size() < 2));
    chk("ng_in_ready", 64'(ngInReady), 64'(model.size() < 2));
    chk("out_valid", 64'(outValid), 64'(model.size() > 0));
    chk("ng_out_valid", 64'(ngOutValid), 64'(model.size() > 0));
    if (model.size() > 0) begin
      h = model[0];
      chk("out_rd", 64'(outRd), 64'(h.rd));
      chk("out_mem_word", 64'(outMem), 64'(h.mem));
      chk("out_alu_result", 64'(outAlu), 64'(h.alu));
      chk("out_mem_to_reg", 64'(outMemToReg), 64'(h.wb[0]));
      chk("out_wb_data", 64'(outWbData), 64'(h.wb[0] ? h.mem : h.alu));
      chk("out_reg_write", 64'(outRegWrite), 64'(h.wb[1] && (h.rd != 5'd0)));
      chk("ng_out_reg_write", 64'(ngOutRegWrite), 64'(h.wb[1]));
      chk("ng_out_wb_data", 64'(ngOutWbData), 64'(h.wb[0] ? h.mem : h.alu));
    end else begin
      chk("idle_reg_write", 64'(outRegWrite), 64'd0);
      chk("idle_mem_to_reg", 64'(outMemToReg), 64'd0);
      chk("ng_idle_reg_write", 64'(ngOutRegWrite), 64'd0);
    end
  endtask

  // One clock: decide transfers from the model, advance it, then compare.
  task automatic step();
    bit    acc, ret;
    bund_t b;
    acc = inValid && (model.size() < 2);
    ret = outReady && (model.size() > 0);
    b   = '{mem: inMem, alu: inAlu, rd: inRd, wb: inWb};
    @(posedge clock);
    if (flush) begin
      model.delete();
    end else begin
      if (ret) void'(model.pop_front());
      if (acc) model.push_back(b);
    end
    #1;
    checkModel();
  endtask

  initial begin
    reset_n  = 1'b0;
    flush    = 1'b0;
    outReady = 1'b0;
    drive(1'b1, 5'd9, 32'h1234, 32'h5678, 2'b11);

    // Held in reset with a valid bundle offered: nothing is taken.
    #12;
    chk("rst_out_valid", 64'(outValid), 64'd0);
    chk("rst_reg_write", 64'(outRegWrite), 64'd0);
    chk("rst_wb_data", 64'(outWbData), 64'd0);
    chk("rst_rd", 64'(outRd), 64'd0);
    chk("rst_mem_word", 64'(outMem), 64'd0);
    chk("rst_alu", 64'(outAlu), 64'd0);
    @(negedge clock);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 2'b00);
    reset_n = 1'b1;
    step();
    chk("post_rst_in_ready", 64'(inReady), 64'd1);
    chk("post_rst_out_valid", 64'(outValid), 64'd0);

    // Streaming at full rate.
    outReady = 1'b1;
    drive(1'b1, 5'd3, 32'hAAAA, 32'h10, 2'b10);
    step();
    chk("stream0_wb_data", 64'(outWbData), 64'h10);
    chk("stream0_rd", 64'(outRd), 64'd3);
    drive(1'b1, 5'd4, 32'hBBBB, 32'h20, 2'b10);
    step();
    chk("stream1_wb_data", 64'(outWbData), 64'h20);
    chk("stream1_in_ready", 64'(inReady), 64'd1);
    drive(1'b1, 5'd5, 32'hCCCC, 32'h30, 2'b10);
    step();
    chk("stream2_wb_data", 64'(outWbData), 64'h30);
    chk("stream2_reg_write", 64'(outRegWrite), 64'd1);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 2'b00);
    step();
    chk("stream_drained", 64'(outValid), 64'd0);

    // Back-pressure fills the skid entry.
    outReady = 1'b0;
    drive(1'b1, 5'd7, 32'hDEAD, 32'h1, 2'b11);
    step();
    drive(1'b1, 5'd8, 32'h2, 32'hB, 2'b10);
    step();
    chk("bp_in_ready", 64'(inReady), 64'd0);
    chk("bp_wb_data", 64'(outWbData), 64'hDEAD);
    chk("bp_rd", 64'(outRd), 64'd7);
    drive(1'b1, 5'd9, 32'h3, 32'hC, 2'b10);
    step();
    chk("bp_hold_rd", 64'(outRd), 64'd7);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 2'b00);
    outReady = 1'b1;
    step();
    chk("bp_second_rd", 64'(outRd), 64'd8);
    chk("bp_second_data", 64'(outWbData), 64'hB);
    step();
    chk("bp_drained", 64'(outValid), 64'd0);

    // Register-0 write suppression.
    outReady = 1'b0;
    drive(1'b1, 5'd0, 32'h0, 32'h55, 2'b10);
    step();
    chk("zero_out_valid", 64'(outValid), 64'd1);
    chk("zero_reg_write", 64'(outRegWrite), 64'd0);
    chk("zero_ng_reg_write", 64'(ngOutRegWrite), 64'd1);
    drive(1'b1, 5'd6, 32'h66, 32'h77, 2'b11);
    step();

    // Flush while full and with a bundle offered.
    flush = 1'b1;
    drive(1'b1, 5'd12, 32'h99, 32'h88, 2'b10);
    step();
    chk("flush_out_valid", 64'(outValid), 64'd0);
    chk("flush_in_ready", 64'(inReady), 64'd1);
    chk("flush_reg_write", 64'(outRegWrite), 64'd0);
    flush = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 2'b00);
    step();
    chk("flush_dropped", 64'(outValid), 64'd0);

    // Asynchronous reset mid-cycle in ONE.
    drive(1'b1, 5'd10, 32'hF00D, 32'h4, 2'b11);
    step();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 2'b00);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(outValid), 64'd0);
    chk("arst_reg_write", 64'(outRegWrite), 64'd0);
    chk("arst_wb_data", 64'(outWbData), 64'd0);
    model.delete();
    @(negedge clock);
    reset_n = 1'b1;
    step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 9) < 7),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
            $urandom(), $urandom(), 2'($urandom_range(0, 3)));
      outReady = 1'($urandom_range(0, 9) < 6);
      flush    = 1'($urandom_range(0, 19) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
